// File: rtl/c2h_source_arbiter_pkg.sv
// Shared C2H definitions: arbiter state encodings, record/bus widths,
// debug counter width and a small modulo helper for rotation arithmetic.
package c2h_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b01,
        ARB_OWN  = 2'b10
    } arb_state_e;

    localparam int C2H_DATA_WIDTH  = 16000;
    localparam int AXIS_DATA_WIDTH = 512;
    localparam int GRANT_CNT_W     = 32;

    // base + off folded back into 0..n-1; off never exceeds n, so one
    // subtraction is enough and no divider is needed.
    function automatic int wrap_add(input int base, input int off, input int n);
        int sum;
        sum = base + off;
        if (sum >= n) begin
            sum = sum - n;
        end else begin
            sum = sum;
        end
        return sum;
    endfunction

endpackage

// File: rtl/c2h_source_arbiter_if.sv
// Handshake bundle between the record producers, the arbiter and the
// C2H packet packager. master = arbiter side, slave = producers/packager.
interface c2h_source_arbiter_if
    import c2h_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = C2H_DATA_WIDTH,
    parameter int SRC_W      = $clog2(NUM_SRC)
);

    logic [NUM_SRC-1:0]            src_en;
    logic [NUM_SRC-1:0]            req_valid;
    logic [NUM_SRC*DATA_WIDTH-1:0] req_data;
    logic [NUM_SRC-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]         pkt_data;
    logic                          pkt_valid;
    logic                          pkt_next;
    logic [SRC_W-1:0]              pkt_src;

    modport master (
        input  src_en,
        input  req_valid,
        input  req_data,
        input  pkt_next,
        output req_ready,
        output pkt_data,
        output pkt_valid,
        output pkt_src
    );

    modport slave (
        output src_en,
        output req_valid,
        output req_data,
        output pkt_next,
        input  req_ready,
        input  pkt_data,
        input  pkt_valid,
        input  pkt_src
    );

endinterface

// File: rtl/c2h_source_arbiter_rr_pick.sv
// Rotate-priority encoder: returns the first eligible source scanning
// owner+1, owner+2, ... with explicit wrap at NUM_SRC. The owner itself is
// examined last, so a lone eligible owner is still found.
module rr_pick
    import c2h_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] elig_i,
    input  logic [SRC_W-1:0]   owner_i,
    output logic [SRC_W-1:0]   grant_o,
    output logic               found_o
);

    int               cand_s;
    logic [SRC_W-1:0] cand_idx_s;

    // Scan from just after the owner; the first eligible candidate wins.
    always_comb begin
        grant_o    = '0;
        found_o    = 1'b0;
        cand_s     = 0;
        cand_idx_s = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand_s     = wrap_add(int'(owner_i), k, NUM_SRC);
            cand_idx_s = SRC_W'(cand_s);
            if (!found_o && elig_i[cand_idx_s]) begin
                grant_o = cand_idx_s;
                found_o = 1'b1;
            end else begin
                found_o = found_o;
            end
        end
    end

endmodule

// File: rtl/c2h_source_arbiter.sv
// Round-robin arbiter sharing the C2H packet packager among NUM_SRC record
// producers. An owner may keep the grant for up to MAX_BURST consecutive
// records while others wait, indefinitely when nobody else is eligible.
// The chosen record lands in a single output register feeding the packager.
module c2h_source_arbiter
    import c2h_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = C2H_DATA_WIDTH,
    parameter int MAX_BURST  = 4,
    parameter int SRC_W      = $clog2(NUM_SRC)
) (
    input  logic                            m_axis_c2h_aclk,
    input  logic                            rst,
    c2h_source_arbiter_if.master            bus,
    output logic [NUM_SRC*GRANT_CNT_W-1:0]  grant_cnt,
    output logic [1:0]                      arb_state
);

    localparam int                 BURST_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
    localparam logic [NUM_SRC-1:0] ONE_HOT0   = {{(NUM_SRC-1){1'b0}}, 1'b1};

    logic                   load_s;
    logic [NUM_SRC-1:0]     elig_s;
    logic                   others_s;
    logic                   stay_s;
    logic [SRC_W-1:0]       pick_idx_s;
    logic                   pick_found_s;
    logic [SRC_W-1:0]       grant_idx_s;
    logic                   accept_s;

    arb_state_e             state_q,     state_d;
    logic [SRC_W-1:0]       owner_q,     owner_d;
    logic [BURST_W-1:0]     burst_q,     burst_d;
    logic                   pkt_valid_q, pkt_valid_d;
    logic [SRC_W-1:0]       pkt_src_q,   pkt_src_d;
    logic [DATA_WIDTH-1:0]  pkt_data_q,  pkt_data_d;
    logic [GRANT_CNT_W-1:0] cnt_q [NUM_SRC];
    logic [GRANT_CNT_W-1:0] cnt_d [NUM_SRC];

    // The output stage may take a new record when empty or being drained.
    assign load_s = !pkt_valid_q | bus.pkt_next;
    assign elig_s = bus.req_valid & bus.src_en;

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_rr_pick (
        .elig_i  (elig_s),
        .owner_i (owner_q),
        .grant_o (pick_idx_s),
        .found_o (pick_found_s)
    );

    // Grant decision: keep the owner inside its burst budget, else rotate.
    always_comb begin
        others_s = |(elig_s & ~(ONE_HOT0 << owner_q));
        if ((state_q == ARB_OWN) && elig_s[owner_q] &&
            ((burst_q < BURST_LAST) || !others_s)) begin
            stay_s = 1'b1;
        end else begin
            stay_s = 1'b0;
        end
        if (stay_s) begin
            grant_idx_s = owner_q;
        end else begin
            grant_idx_s = pick_idx_s;
        end
        // No accept is offered while reset is asserted.
        accept_s = load_s & (stay_s | pick_found_s) & !rst;
        for (int i = 0; i < NUM_SRC; i++) begin
            bus.req_ready[i] = accept_s && (grant_idx_s == SRC_W'(i));
        end
    end

    // FSM next state, owner tracking and burst length accounting.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        burst_d = burst_q;
        case (state_q)
            ARB_IDLE: begin
                if (accept_s) begin
                    state_d = ARB_OWN;
                    owner_d = grant_idx_s;
                    burst_d = '0;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_OWN: begin
                if (accept_s) begin
                    state_d = ARB_OWN;
                    owner_d = grant_idx_s;
                    if (grant_idx_s == owner_q) begin
                        if (burst_q < BURST_LAST) begin
                            burst_d = burst_q + BURST_W'(1);
                        end else begin
                            burst_d = burst_q;
                        end
                    end else begin
                        burst_d = '0;
                    end
                end else if (load_s) begin
                    // Nothing eligible: owner is kept so rotation stays fair.
                    state_d = ARB_IDLE;
                end else begin
                    state_d = ARB_OWN;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Output stage and debug counters: capture on accept, empty on idle load.
    always_comb begin
        pkt_valid_d = pkt_valid_q;
        pkt_src_d   = pkt_src_q;
        pkt_data_d  = pkt_data_q;
        cnt_d       = cnt_q;
        if (accept_s) begin
            pkt_valid_d          = 1'b1;
            pkt_src_d            = grant_idx_s;
            pkt_data_d           = bus.req_data[int'(grant_idx_s)*DATA_WIDTH +: DATA_WIDTH];
            cnt_d[grant_idx_s]   = cnt_q[grant_idx_s] + GRANT_CNT_W'(1);
        end else if (load_s) begin
            pkt_valid_d = 1'b0;
        end else begin
            pkt_valid_d = pkt_valid_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge m_axis_c2h_aclk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            owner_q     <= SRC_W'(NUM_SRC - 1);
            burst_q     <= '0;
            pkt_valid_q <= 1'b0;
            pkt_src_q   <= '0;
            pkt_data_q  <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            burst_q     <= burst_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_src_q   <= pkt_src_d;
            pkt_data_q  <= pkt_data_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.pkt_valid = pkt_valid_q;
    assign bus.pkt_src   = pkt_src_q;
    assign bus.pkt_data  = pkt_data_q;
    assign arb_state     = state_q;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_cnt_out
        assign grant_cnt[gi*GRANT_CNT_W +: GRANT_CNT_W] = cnt_q[gi];
    end

endmodule
